// File: rtl/reorder_buffer_mo.sv
// rtl/reorder_buffer_mo.sv - read reorder buffer returning out-of-order R beats in AR issue order
module reorder_buffer_mo #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          s_arid_i,
  input  logic                         s_arvalid_i,
  output logic                         s_arready_o,
  output logic [DATA_WIDTH-1:0]        s_rdata_o,
  output logic [ID_WIDTH-1:0]          s_rid_o,
  output logic [1:0]                   s_rresp_o,
  output logic                         s_rvalid_o,
  input  logic                         s_rready_i,
  output logic [ID_WIDTH-1:0]          m_arid_o,
  output logic                         m_arvalid_o,
  input  logic                         m_arready_i,
  input  logic [DATA_WIDTH-1:0]        m_rdata_i,
  input  logic [ID_WIDTH-1:0]          m_rid_i,
  input  logic [1:0]                   m_rresp_i,
  input  logic                         m_rvalid_i,
  output logic                         m_rready_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         err_unexp_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]      slot_valid;
  logic [DEPTH-1:0]      slot_filled;
  logic [ID_WIDTH-1:0]   slot_id   [DEPTH];
  logic [DATA_WIDTH-1:0] slot_data [DEPTH];
  logic [1:0]            slot_resp [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             ar_hs;
  logic             r_hs;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic [PTR_W-1:0] scan_idx;

  // Occupancy alone decides full; pointers are equal both when empty and when full.
  assign full        = (count_o == CNT_W'(DEPTH));
  assign s_arready_o = m_arready_i & ~full;
  assign m_arvalid_o = s_arvalid_i & ~full;
  assign m_arid_o    = s_arid_i;
  assign m_rready_o  = 1'b1;
  assign ar_hs       = s_arvalid_i & s_arready_o;

  assign s_rvalid_o  = slot_valid[rd_ptr] & slot_filled[rd_ptr];
  assign s_rid_o     = slot_id[rd_ptr];
  assign s_rdata_o   = slot_data[rd_ptr];
  assign s_rresp_o   = slot_resp[rd_ptr];
  assign r_hs        = s_rvalid_o & s_rready_i;

  // Find the oldest pending, unfilled slot for the incoming RID, scanning from the head in age order.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + PTR_W'(k);
      if (!hit && slot_valid[scan_idx] && !slot_filled[scan_idx] &&
          (slot_id[scan_idx] == m_rid_i)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  // Slot table, pointers, occupancy and the unexpected-RID pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid  <= '0;
      slot_filled <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      err_unexp_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_id[i]   <= '0;
        slot_data[i] <= '0;
        slot_resp[i] <= '0;
      end
    end else begin
      err_unexp_o <= m_rvalid_i & ~hit;

      // AR allocation only ever lands on a free slot, so it never collides with fill or pop.
      if (ar_hs) begin
        slot_valid[wr_ptr]  <= 1'b1;
        slot_filled[wr_ptr] <= 1'b0;
        slot_id[wr_ptr]     <= s_arid_i;
        wr_ptr              <= wr_ptr + 1'b1;
      end

      // Fill targets an unfilled slot while pop needs a filled one, so they never coincide.
      if (m_rvalid_i && hit) begin
        slot_data[hit_idx]   <= m_rdata_i;
        slot_resp[hit_idx]   <= m_rresp_i;
        slot_filled[hit_idx] <= 1'b1;
      end

      if (r_hs) begin
        slot_valid[rd_ptr]  <= 1'b0;
        slot_filled[rd_ptr] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end

      case ({ar_hs, r_hs})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer_mo.sv
// tb/tb_reorder_buffer_mo.sv - scoreboard bench for reorder_buffer_mo
module tb_reorder_buffer_mo;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_arid_i;
  logic       s_arvalid_i;
  logic       s_arready_o;
  logic [7:0] s_rdata_o;
  logic [3:0] s_rid_o;
  logic [1:0] s_rresp_o;
  logic       s_rvalid_o;
  logic       s_rready_i;
  logic [3:0] m_arid_o;
  logic       m_arvalid_o;
  logic       m_arready_i;
  logic [7:0] m_rdata_i;
  logic [3:0] m_rid_i;
  logic [1:0] m_rresp_i;
  logic       m_rvalid_i;
  logic       m_rready_o;
  logic [3:0] count_o;
  logic       err_unexp_o;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
    logic [1:0] resp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  reorder_buffer_mo #(.DATA_WIDTH(8), .ID_WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o), .s_rresp_o(s_rresp_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i), .m_rresp_i(m_rresp_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .count_o(count_o), .err_unexp_o(err_unexp_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one AR; the caller has already pushed the expected response.
  task automatic do_ar(input logic [3:0] id);
    s_arid_i    = id;
    s_arvalid_i = 1'b1;
    #1 check("ar_ready", {31'd0, s_arready_o}, 32'd1);
    @(posedge clk); #1;
    s_arvalid_i = 1'b0;
  endtask

  task automatic do_rin(input logic [3:0] id, input logic [7:0] data, input logic [1:0] resp);
    m_rid_i    = id;
    m_rdata_i  = data;
    m_rresp_i  = resp;
    m_rvalid_i = 1'b1;
    @(posedge clk); #1;
    m_rvalid_i = 1'b0;
  endtask

  // Wait (bounded) for an upstream beat, compare against the scoreboard head, accept it.
  task automatic do_pop();
    exp_t e;
    int   n = 0;
    while (!s_rvalid_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_rvalid_o) begin
      check("pop_timeout", {31'd0, s_rvalid_o}, 32'd1);
    end else if (sb.size() == 0) begin
      check("pop_unexpected", {31'd0, s_rvalid_o}, 32'd0);
    end else begin
      e = sb.pop_front();
      check("pop_id",   {28'd0, s_rid_o},   {28'd0, e.id});
      check("pop_data", {24'd0, s_rdata_o}, {24'd0, e.data});
      check("pop_resp", {30'd0, s_rresp_o}, {30'd0, e.resp});
      s_rready_i = 1'b1;
      @(posedge clk); #1;
      s_rready_i = 1'b0;
    end
  endtask

  // Directed sequence: reset, reorder, same-ID, full, backpressure, wrap, unexpected, mid-run reset.
  initial begin
    exp_t held;
    rst = 1'b1; s_arid_i = '0; s_arvalid_i = 1'b0; s_rready_i = 1'b0;
    m_arready_i = 1'b1; m_rdata_i = '0; m_rid_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_count",   {28'd0, count_o},     32'd0);
    check("rst_rvalid",  {31'd0, s_rvalid_o},  32'd0);
    check("rst_arready", {31'd0, s_arready_o}, 32'd1);
    check("rst_err",     {31'd0, err_unexp_o}, 32'd0);
    check("rst_rdata",   {24'd0, s_rdata_o},   32'd0);
    m_arready_i = 1'b0;
    #1 check("arready_follows_m", {31'd0, s_arready_o}, 32'd0);
    m_arready_i = 1'b1;
    check("m_rready_tied", {31'd0, m_rready_o}, 32'd1);

    // Reorder: issued 1,2,3; returned 3,1,2.
    sb.push_back('{4'd1, 8'hA1, 2'b00}); do_ar(4'd1);
    sb.push_back('{4'd2, 8'hB2, 2'b00}); do_ar(4'd2);
    sb.push_back('{4'd3, 8'hC3, 2'b00}); do_ar(4'd3);
    check("reorder_count", {28'd0, count_o}, 32'd3);
    do_rin(4'd3, 8'hC3, 2'b00);
    check("reorder_head_blocked", {31'd0, s_rvalid_o}, 32'd0);
    do_rin(4'd1, 8'hA1, 2'b00);
    check("reorder_latency1", {31'd0, s_rvalid_o}, 32'd1);
    do_rin(4'd2, 8'hB2, 2'b00);
    repeat (3) do_pop();
    check("reorder_empty", {28'd0, count_o}, 32'd0);

    // Same ID twice: beats fill oldest first.
    sb.push_back('{4'd5, 8'h11, 2'b00}); do_ar(4'd5);
    sb.push_back('{4'd5, 8'h22, 2'b10}); do_ar(4'd5);
    do_rin(4'd5, 8'h11, 2'b00);
    do_rin(4'd5, 8'h22, 2'b10);
    repeat (2) do_pop();

    // Full: eight outstanding, then a pop frees one slot on the following cycle.
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{4'(i), 8'(8'h40 + i), 2'b00});
      do_ar(4'(i));
    end
    check("full_count",   {28'd0, count_o},     32'd8);
    check("full_arready", {31'd0, s_arready_o}, 32'd0);
    s_arvalid_i = 1'b1;
    #1 check("full_m_arvalid", {31'd0, m_arvalid_o}, 32'd0);
    s_arvalid_i = 1'b0;
    do_rin(4'd0, 8'h40, 2'b00);
    check("full_arready_before_pop", {31'd0, s_arready_o}, 32'd0);
    do_pop();
    check("full_arready_after_pop", {31'd0, s_arready_o}, 32'd1);
    check("full_count_after_pop",   {28'd0, count_o},     32'd7);
    for (int i = 7; i >= 1; i--) do_rin(4'(i), 8'(8'h40 + i), 2'b00);
    repeat (7) do_pop();

    // Backpressure: head payload must hold while s_rready_i is low.
    held = '{4'd9, 8'h5A, 2'b01};
    sb.push_back(held); do_ar(4'd9);
    do_rin(4'd9, 8'h5A, 2'b01);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", {19'd0, s_rvalid_o, s_rid_o, s_rdata_o},
            {19'd0, 1'b1, held.id, held.data});
      @(posedge clk); #1;
    end
    do_pop();

    // Wrap: 20 transactions, two outstanding at a time and returned swapped.
    for (int i = 0; i < 20; i += 2) begin
      sb.push_back('{4'(i % 16), 8'(i * 7 + 3), 2'(i % 4)});           do_ar(4'(i % 16));
      sb.push_back('{4'((i + 1) % 16), 8'(i * 7 + 10), 2'((i + 1) % 4)}); do_ar(4'((i + 1) % 16));
      do_rin(4'((i + 1) % 16), 8'(i * 7 + 10), 2'((i + 1) % 4));
      do_rin(4'(i % 16), 8'(i * 7 + 3), 2'(i % 4));
      repeat (2) do_pop();
    end
    check("wrap_empty", {28'd0, count_o}, 32'd0);
    check("wrap_sb_drained", sb.size(), 32'd0);

    // Unexpected RID while another read is pending.
    sb.push_back('{4'd3, 8'h77, 2'b00}); do_ar(4'd3);
    do_rin(4'd7, 8'hEE, 2'b00);
    check("unexp_err",    {31'd0, err_unexp_o}, 32'd1);
    check("unexp_count",  {28'd0, count_o},     32'd1);
    check("unexp_rvalid", {31'd0, s_rvalid_o},  32'd0);
    @(posedge clk); #1;
    check("unexp_err_pulse", {31'd0, err_unexp_o}, 32'd0);
    do_rin(4'd3, 8'h77, 2'b00);
    check("expected_no_err", {31'd0, err_unexp_o}, 32'd0);
    do_pop();

    // Reset mid-operation discards the outstanding read; its late beat is unexpected.
    sb.push_back('{4'd4, 8'h99, 2'b00}); do_ar(4'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("midrst_count", {28'd0, count_o}, 32'd0);
    do_rin(4'd4, 8'h99, 2'b00);
    check("midrst_late_err", {31'd0, err_unexp_o}, 32'd1);
    check("midrst_rvalid",   {31'd0, s_rvalid_o},  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
